// File: rtl/lr_pkg.sv
// Shared types for the logistic-regression feature sequencer: widths, FSM states
// and the packed sample word carried through the input FIFO.
package lr_pkg;

  localparam int unsigned FEAT_W = 32;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned WORD_W = 2 * FEAT_W;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } lr_state_e;

  typedef logic [WORD_W-1:0] sample_word_t;

  // feature0 occupies the low half of the sample word
  function automatic sample_word_t pack_sample(input logic [FEAT_W-1:0] f0,
                                               input logic [FEAT_W-1:0] f1);
    return {f1, f0};
  endfunction

endpackage

// File: rtl/lr_sample_fifo.sv
// Synchronous FIFO of packed feature pairs; registered count, head word visible while non-empty.
module lr_sample_fifo
  import lr_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  sample_word_t           din,
  output sample_word_t           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sample_word_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage is not reset; a cleared count is enough to discard stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lr_feature_sequencer.sv
// Feeds buffered feature pairs to the regression core one at a time and returns each
// result tagged with a wrapping sequence number on a valid/ready output.
module lr_feature_sequencer
  import lr_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned TAG_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [FEAT_W-1:0]      s_feature0,
  input  logic [FEAT_W-1:0]      s_feature1,
  output logic                   read_enable,
  output logic [FEAT_W-1:0]      feature0,
  output logic [FEAT_W-1:0]      feature1,
  input  logic [RES_W-1:0]       result,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [RES_W-1:0]       r_data,
  output logic [TAG_W-1:0]       r_tag,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int unsigned WAIT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  lr_state_e         r_state;
  lr_state_e         w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic [TAG_W-1:0]  r_tag_cnt;
  logic [FEAT_W-1:0] r_feature0;
  logic [FEAT_W-1:0] r_feature1;
  logic              r_read_enable;
  logic [RES_W-1:0]  r_res_data;
  logic [TAG_W-1:0]  r_res_tag;
  logic              w_fifo_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_capture;
  sample_word_t      w_fifo_dout;

  lr_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (s_valid && s_ready),
    .pop  (w_fifo_pop),
    .din  (pack_sample(s_feature0, s_feature1)),
    .dout (w_fifo_dout),
    .full (w_fifo_full),
    .empty(w_fifo_empty),
    .count(fifo_count)
  );

  assign s_ready     = !w_fifo_full;
  assign busy        = (r_state != StIdle);
  assign r_valid     = (r_state == StHold);
  assign read_enable = r_read_enable;
  assign feature0    = r_feature0;
  assign feature1    = r_feature1;
  assign r_data      = r_res_data;
  assign r_tag       = r_res_tag;

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_fifo_pop      = 1'b0;
    w_capture       = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_fifo_empty) begin
          w_fifo_pop   = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_wait_cnt_next = WAIT_W'(CORE_LAT - 1);
        w_state_next    = StWait;
      end
      StWait: begin
        // Counter reaches zero in the cycle the core's result is valid
        if (r_wait_cnt == '0) begin
          w_capture    = 1'b1;
          w_state_next = StHold;
        end else begin
          w_wait_cnt_next = r_wait_cnt - WAIT_W'(1);
        end
      end
      StHold: begin
        if (r_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_wait_cnt    <= '0;
      r_tag_cnt     <= '0;
      r_feature0    <= '0;
      r_feature1    <= '0;
      r_read_enable <= 1'b0;
      r_res_data    <= '0;
      r_res_tag     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_read_enable <= w_fifo_pop;
      if (w_fifo_pop) begin
        {r_feature1, r_feature0} <= w_fifo_dout;
      end
      if (w_capture) begin
        r_res_data <= result;
        r_res_tag  <= r_tag_cnt;
        r_tag_cnt  <= r_tag_cnt + TAG_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lr_feature_sequencer.sv
// Bench for lr_feature_sequencer: two instances (CORE_LAT=1/TAG_W=8 and CORE_LAT=3/TAG_W=4),
// each with a stub core and a transaction-level scoreboard of expected (sum, tag) results.
module tb_lr_feature_sequencer;

  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        reset   [2];
  logic        s_valid [2];
  logic [31:0] s_f0    [2];
  logic [31:0] s_f1    [2];
  logic        r_ready [2];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    localparam int unsigned TW  = (g == 0) ? 8 : 4;

    logic          s_ready, read_enable, r_valid, busy;
    logic [31:0]   feature0, feature1, result, r_data;
    logic [TW-1:0] r_tag;
    logic [3:0]    fifo_count;
    logic [31:0]   pipe [LAT];

    lr_feature_sequencer #(
      .DEPTH   (DEPTH),
      .CORE_LAT(LAT),
      .TAG_W   (TW)
    ) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .s_valid    (s_valid[g]),
      .s_ready    (s_ready),
      .s_feature0 (s_f0[g]),
      .s_feature1 (s_f1[g]),
      .read_enable(read_enable),
      .feature0   (feature0),
      .feature1   (feature1),
      .result     (result),
      .r_valid    (r_valid),
      .r_ready    (r_ready[g]),
      .r_data     (r_data),
      .r_tag      (r_tag),
      .fifo_count (fifo_count),
      .busy       (busy)
    );

    // Stub core: sum registered on read_enable, valid exactly LAT cycles after it
    always @(posedge clk) begin
      if (read_enable) pipe[0] <= feature0 + feature1;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign result = pipe[LAT-1];

    logic [31:0] q_data[$];
    logic [7:0]  q_tag[$];
    int unsigned tag_cnt  = 0;
    int          n_out    = 0;
    logic [7:0]  last_tag = 8'hFF;
    logic        held     = 1'b0;
    logic [31:0] held_data;
    logic [7:0]  held_tag;

    initial forever begin
      @(negedge clk);
      if (reset[g] === 1'b1) begin
        q_data.delete();
        q_tag.delete();
        tag_cnt  = 0;
        held     = 1'b0;
        last_tag = 8'hFF;
      end else begin
        if (held) begin
          check_eq("hold_r_valid", r_valid, 1'b1);
          check_eq("hold_r_data", r_data, held_data);
          check_eq("hold_r_tag", r_tag, held_tag);
        end
        held      = r_valid && !r_ready[g];
        held_data = r_data;
        held_tag  = 8'(r_tag);
        if (s_valid[g] && s_ready) begin
          q_data.push_back(s_f0[g] + s_f1[g]);
          q_tag.push_back(8'(tag_cnt % (1 << TW)));
          tag_cnt++;
        end
        if (r_valid && r_ready[g]) begin
          check_eq("result_pending", q_data.size() != 0, 1'b1);
          if (q_data.size() != 0) begin
            check_eq("r_data", r_data, q_data.pop_front());
            check_eq("r_tag", r_tag, q_tag.pop_front());
          end
          n_out++;
          last_tag = 8'(r_tag);
        end
      end
    end
  end

  function automatic logic ready_of(input int ch);
    return (ch == 0) ? g_ch[0].s_ready : g_ch[1].s_ready;
  endfunction

  function automatic logic busy_of(input int ch);
    return (ch == 0) ? g_ch[0].busy : g_ch[1].busy;
  endfunction

  function automatic int pending(input int ch);
    return (ch == 0) ? g_ch[0].q_data.size() : g_ch[1].q_data.size();
  endfunction

  // All tasks start and end just after a rising edge
  task automatic do_reset(input int ch);
    reset[ch] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset[ch] = 1'b0;
  endtask

  task automatic send(input int ch, input logic [31:0] f0, input logic [31:0] f1);
    logic done;
    done        = 1'b0;
    s_valid[ch] = 1'b1;
    s_f0[ch]    = f0;
    s_f1[ch]    = f1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = ready_of(ch);
      @(posedge clk);
      #1;
    end
    s_valid[ch] = 1'b0;
    check_eq("send_accepted", done, 1'b1);
  endtask

  task automatic drain(input int ch);
    r_ready[ch] = 1'b1;
    for (int i = 0; i < 600 && (pending(ch) != 0 || busy_of(ch)); i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain_pending", pending(ch), 0);
  endtask

  task automatic rand_traffic(input int ch, input int n);
    logic acc;
    s_valid[ch] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc = s_valid[ch] && ready_of(ch);
      @(posedge clk);
      #1;
      if (!s_valid[ch] || acc) begin
        s_valid[ch] = ($urandom_range(0, 3) != 0);
        s_f0[ch]    = $urandom;
        s_f1[ch]    = $urandom;
      end
      r_ready[ch] = 1'($urandom_range(0, 1));
    end
    s_valid[ch] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] re_seen, rv_seen, bz_seen;
    logic       hit, rv_any;
    int         acc, n0;

    for (int c = 0; c < 2; c++) begin
      reset[c]   = 1'b1;
      s_valid[c] = 1'b0;
      s_f0[c]    = '0;
      s_f1[c]    = '0;
      r_ready[c] = 1'b0;
    end

    // 1: reset state
    repeat (3) @(posedge clk);
    #1 reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    check_eq("rst_s_ready", g_ch[0].s_ready, 1'b1);
    check_eq("rst_busy", g_ch[0].busy, 1'b0);
    check_eq("rst_fifo_count", g_ch[0].fifo_count, 4'd0);
    check_eq("rst_read_enable", g_ch[0].read_enable, 1'b0);
    check_eq("rst_r_valid", g_ch[0].r_valid, 1'b0);
    check_eq("rst_features", {g_ch[0].feature1, g_ch[0].feature0}, 64'd0);
    check_eq("rst_r_data", g_ch[0].r_data, 32'd0);
    check_eq("rst_r_tag", g_ch[0].r_tag, 8'd0);
    check_eq("rst_b_s_ready", g_ch[1].s_ready, 1'b1);
    check_eq("rst_b_busy", g_ch[1].busy, 1'b0);

    // 2: single sample latency, CORE_LAT=1
    @(posedge clk);
    #1 r_ready[0] = 1'b1;
    s_valid[0] = 1'b1;
    s_f0[0]    = 32'd12;
    s_f1[0]    = 32'd8;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      re_seen[k] = g_ch[0].read_enable;
      rv_seen[k] = g_ch[0].r_valid;
      bz_seen[k] = g_ch[0].busy;
      if (k == 2) begin
        check_eq("issue_feature0", g_ch[0].feature0, 32'd12);
        check_eq("issue_feature1", g_ch[0].feature1, 32'd8);
      end
      if (k == 4) begin
        check_eq("single_r_data", g_ch[0].r_data, 32'd20);
        check_eq("single_r_tag", g_ch[0].r_tag, 8'd0);
      end
      if (k == 0) begin
        @(posedge clk);
        #1 s_valid[0] = 1'b0;
      end
    end
    check_eq("read_enable_timing", re_seen, 8'b0000_0100);
    check_eq("r_valid_timing", rv_seen, 8'b0001_0000);
    check_eq("busy_timing", bz_seen, 8'b0001_1100);
    @(posedge clk);
    #1;

    // 3: capacity with r_ready low, then in-order drain
    do_reset(0);
    r_ready[0] = 1'b0;
    n0         = g_ch[0].n_out;
    acc        = 0;
    s_valid[0] = 1'b1;
    s_f0[0]    = $urandom;
    s_f1[0]    = $urandom;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      hit = s_valid[0] && ready_of(0);
      if (hit) acc++;
      @(posedge clk);
      #1;
      if (acc >= 12) s_valid[0] = 1'b0;
      else if (hit) begin
        s_f0[0] = $urandom;
        s_f1[0] = $urandom;
      end
    end
    s_valid[0] = 1'b0;
    check_eq("capacity_accepted", acc, 9);
    @(negedge clk);
    check_eq("full_s_ready", g_ch[0].s_ready, 1'b0);
    check_eq("full_fifo_count", g_ch[0].fifo_count, 4'd8);
    check_eq("full_r_valid", g_ch[0].r_valid, 1'b1);
    check_eq("full_r_tag", g_ch[0].r_tag, 8'd0);
    @(posedge clk);
    #1 drain(0);
    check_eq("capacity_results", g_ch[0].n_out - n0, 9);

    // 4: random valid/ready on both instances
    fork
      rand_traffic(0, 500);
      rand_traffic(1, 500);
    join
    drain(0);
    drain(1);

    // 5: TAG_W=4 wraps after 15
    do_reset(1);
    r_ready[1] = 1'b1;
    n0         = g_ch[1].n_out;
    for (int i = 0; i < 17; i++) send(1, $urandom, $urandom);
    drain(1);
    check_eq("wrap_count", g_ch[1].n_out - n0, 17);
    check_eq("wrap_last_tag", g_ch[1].last_tag, 8'd0);

    // 6: reset during WAIT with CORE_LAT=3
    do_reset(1);
    r_ready[1] = 1'b1;
    send(1, 32'd100, 32'd5);
    send(1, 32'd7, 32'd9);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      hit = g_ch[1].read_enable;
    end
    check_eq("wait_reached", hit, 1'b1);
    @(posedge clk);
    #1 reset[1] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("midrst_r_valid", g_ch[1].r_valid, 1'b0);
    check_eq("midrst_busy", g_ch[1].busy, 1'b0);
    check_eq("midrst_read_enable", g_ch[1].read_enable, 1'b0);
    check_eq("midrst_fifo_count", g_ch[1].fifo_count, 4'd0);
    check_eq("midrst_s_ready", g_ch[1].s_ready, 1'b1);
    check_eq("midrst_feature0", g_ch[1].feature0, 32'd0);
    @(posedge clk);
    #1 reset[1] = 1'b0;
    n0     = g_ch[1].n_out;
    rv_any = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rv_any = rv_any | g_ch[1].r_valid;
    end
    check_eq("flushed_no_r_valid", rv_any, 1'b0);
    @(posedge clk);
    #1 send(1, 32'hFFFF_FFFF, 32'd2);
    drain(1);
    check_eq("post_rst_count", g_ch[1].n_out - n0, 1);
    check_eq("post_rst_tag", g_ch[1].last_tag, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
